// File: rtl/intr_ack_sched.sv
// intr_ack_sched
//   Round-robin interrupt vector scheduler. Rising edges on intr latch a
//   pending bit. Enabled pending sources are granted one at a time as a
//   vector request that stays up until the consumer acknowledges it or a
//   timeout expires. Every delivery attempt is followed by an idle gap.
//
// Ports
//   clk           in   clock, rising edge active
//   rst_n         in   asynchronous active-low reset
//   intr          in   [PORTS] level interrupt sources
//   intr_en       in   [PORTS] per-source grant enable
//   intr_vec_ack  in   consumer acknowledge of the current request
//   intr_vec_req  out  vector request
//   intr_num      out  [32] granted source index, zero-extended
//   pending       out  [PORTS] pending register
//   busy          out  high whenever the FSM is not idle
//   timeout_err   out  one-cycle pulse per timeout
module intr_ack_sched #(
    parameter int PORTS   = 4,
    parameter int TIMEOUT = 16,
    parameter int HOLDOFF = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] intr,
    input  logic [PORTS-1:0] intr_en,
    input  logic             intr_vec_ack,
    output logic             intr_vec_req,
    output logic [31:0]      intr_num,
    output logic [PORTS-1:0] pending,
    output logic             busy,
    output logic             timeout_err
);

    localparam int               PTR_W    = $clog2(PORTS);
    localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0]       GAP_LOAD = 8'(HOLDOFF);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PORTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] intr_q, intr_d;
    logic [PORTS-1:0] pending_q, pending_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       tcnt_q, tcnt_d;
    logic [7:0]       gcnt_q, gcnt_d;
    logic             req_q, req_d;
    logic [31:0]      num_q, num_d;
    logic             terr_q, terr_d;

    logic [PORTS-1:0] rise;
    logic [PORTS-1:0] eligible;
    logic [PORTS-1:0] clr;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] pick;

    // Lowest requesting index at or above base; if none, lowest overall.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [PORTS-1:0] req,
                                                 input logic [PTR_W-1:0] base);
        logic [PTR_W-1:0] lo_any;
        logic [PTR_W-1:0] lo_above;
        logic             hit_above;
        lo_any    = '0;
        lo_above  = '0;
        hit_above = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = PTR_W'(i);
                if (i >= int'(base)) begin
                    lo_above  = PTR_W'(i);
                    hit_above = 1'b1;
                end
            end
        end
        return hit_above ? lo_above : lo_any;
    endfunction

    assign rise     = intr & ~intr_q;
    assign eligible = pending_q & intr_en;
    assign grant    = num_q[PTR_W-1:0];
    assign next_ptr = (grant == LAST_IDX) ? '0 : grant + PTR_W'(1);
    assign pick     = rr_pick(eligible, ptr_q);

    always_comb begin
        state_d = state_q;
        intr_d  = intr;
        ptr_d   = ptr_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        req_d   = req_q;
        num_d   = num_q;
        terr_d  = 1'b0;
        clr     = '0;

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    num_d   = 32'(pick);
                    req_d   = 1'b1;
                    tcnt_d  = 8'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Ack has priority over a timeout landing on the same edge.
                if (intr_vec_ack) begin
                    req_d      = 1'b0;
                    clr[grant] = 1'b1;
                    ptr_d      = next_ptr;
                    gcnt_d     = GAP_LOAD;
                    state_d    = GAP;
                end else if (tcnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    terr_d  = 1'b1;
                    ptr_d   = next_ptr;
                    gcnt_d  = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            GAP: begin
                // The arbitration cycle spent in IDLE is the last low cycle
                // of the gap, so leave GAP once the decremented count is 1.
                gcnt_d = gcnt_q - 8'd1;
                if (gcnt_q <= 8'd2) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A rise on the bit being cleared wins, so the source stays pending.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            intr_q    <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
            tcnt_q    <= 8'd0;
            gcnt_q    <= 8'd0;
            req_q     <= 1'b0;
            num_q     <= 32'd0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            intr_q    <= intr_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
            req_q     <= req_d;
            num_q     <= num_d;
            terr_q    <= terr_d;
        end
    end

    assign intr_vec_req = req_q;
    assign intr_num     = num_q;
    assign pending      = pending_q;
    assign busy         = (state_q != IDLE);
    assign timeout_err  = terr_q;

endmodule
